// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: region FSMs per axis, registered syncs, coordinates and strobes.
// Optional ADV7123 DAC control pins are enabled by defining VGA_TIMING_ADV7123_EN.
module vga_timing_gen #(
  parameter int HVA       = 640,
  parameter int HFP       = 16,
  parameter int HSP       = 96,
  parameter int HBP       = 48,
  parameter int VVA       = 480,
  parameter int VFP       = 10,
  parameter int VSP       = 2,
  parameter int VBP       = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic                    clk_vga,
  input  logic                    rst,
  input  logic                    en,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_video_on,
  output logic [$clog2(HVA)-1:0]  pixel_x,
  output logic [$clog2(VVA)-1:0]  pixel_y,
  output logic                    first_pixel,
  output logic                    line_end,
  output logic                    frame_end
`ifdef VGA_TIMING_ADV7123_EN
  ,
  output logic                    adv7123_vga_blank_n,
  output logic                    adv7123_vga_sync_n,
  output logic                    adv7123_vga_clk
`endif
);

  localparam int HT = HVA + HFP + HSP + HBP;
  localparam int VT = VVA + VFP + VSP + VBP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int XW = $clog2(HVA);
  localparam int YW = $clog2(VVA);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_BP0  = HW'(HSP);
  localparam logic [HW-1:0] H_VA0  = HW'(HSP + HBP);
  localparam logic [HW-1:0] H_FP0  = HW'(HSP + HBP + HVA);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_BP0  = VW'(VSP);
  localparam logic [VW-1:0] V_VA0  = VW'(VSP + VBP);
  localparam logic [VW-1:0] V_FP0  = VW'(VSP + VBP + VVA);

  if (HVA < 1 || HFP < 1 || HSP < 1 || HBP < 1 ||
      VVA < 1 || VFP < 1 || VSP < 1 || VBP < 1) begin : g_bad_params
    $fatal(1, "vga_timing_gen: every timing parameter must be >= 1");
  end

  typedef enum logic [3:0] {
    SP = 4'b0001,
    BP = 4'b0010,
    VA = 4'b0100,
    FP = 4'b1000
  } region_t;

  region_t       h_state, h_state_nxt;
  region_t       v_state, v_state_nxt;
  logic [HW-1:0] h_cnt, h_cnt_nxt;
  logic [VW-1:0] v_cnt, v_cnt_nxt;
  logic          h_wrap;

  logic          hsync_nxt;
  logic          vsync_nxt;
  logic          video_on_nxt;
  logic [XW-1:0] pixel_x_nxt;
  logic [YW-1:0] pixel_y_nxt;
  logic          first_pixel_nxt;
  logic          line_end_nxt;
  logic          frame_end_nxt;

  // Counters; a low enable parks both axes at the origin.
  always_comb begin
    h_wrap    = (h_cnt == H_LAST);
    h_cnt_nxt = h_wrap ? '0 : h_cnt + 1'b1;
    v_cnt_nxt = v_cnt;
    if (h_wrap) begin
      v_cnt_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
    if (!en) begin
      h_cnt_nxt = '0;
      v_cnt_nxt = '0;
    end
  end

  // Horizontal region FSM, stepped by the count it is about to hold.
  always_comb begin
    h_state_nxt = h_state;
    case (h_state)
      SP:      if (h_cnt_nxt == H_BP0) h_state_nxt = BP;
      BP:      if (h_cnt_nxt == H_VA0) h_state_nxt = VA;
      VA:      if (h_cnt_nxt == H_FP0) h_state_nxt = FP;
      FP:      if (h_cnt_nxt == '0)    h_state_nxt = SP;
      default: h_state_nxt = SP;
    endcase
    if (!en) begin
      h_state_nxt = SP;
    end
  end

  // Vertical region FSM only moves on the last clock of a line.
  always_comb begin
    v_state_nxt = v_state;
    if (h_wrap) begin
      case (v_state)
        SP:      if (v_cnt_nxt == V_BP0) v_state_nxt = BP;
        BP:      if (v_cnt_nxt == V_VA0) v_state_nxt = VA;
        VA:      if (v_cnt_nxt == V_FP0) v_state_nxt = FP;
        FP:      if (v_cnt_nxt == '0)    v_state_nxt = SP;
        default: v_state_nxt = SP;
      endcase
    end
    if (!en) begin
      v_state_nxt = SP;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_state <= SP;
      v_state <= SP;
    end else begin
      h_cnt   <= h_cnt_nxt;
      v_cnt   <= v_cnt_nxt;
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
    end
  end

  // Output terms decode the current counter state; they appear one clock later.
  always_comb begin
    hsync_nxt       = ~HSYNC_POL;
    vsync_nxt       = ~VSYNC_POL;
    video_on_nxt    = 1'b0;
    pixel_x_nxt     = '0;
    pixel_y_nxt     = '0;
    first_pixel_nxt = 1'b0;
    line_end_nxt    = 1'b0;
    frame_end_nxt   = 1'b0;
    if (en) begin
      hsync_nxt       = (h_state == SP) ? HSYNC_POL : ~HSYNC_POL;
      vsync_nxt       = (v_state == SP) ? VSYNC_POL : ~VSYNC_POL;
      video_on_nxt    = (h_state == VA) && (v_state == VA);
      if (h_state == VA) begin
        pixel_x_nxt = XW'(h_cnt - H_VA0);
      end
      if (v_state == VA) begin
        pixel_y_nxt = YW'(v_cnt - V_VA0);
      end
      first_pixel_nxt = (h_cnt == H_VA0) && (v_cnt == V_VA0);
      line_end_nxt    = h_wrap;
      frame_end_nxt   = h_wrap && (v_cnt == V_LAST);
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vga_hsync    <= ~HSYNC_POL;
      vga_vsync    <= ~VSYNC_POL;
      vga_video_on <= 1'b0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      first_pixel  <= 1'b0;
      line_end     <= 1'b0;
      frame_end    <= 1'b0;
    end else begin
      vga_hsync    <= hsync_nxt;
      vga_vsync    <= vsync_nxt;
      vga_video_on <= video_on_nxt;
      pixel_x      <= pixel_x_nxt;
      pixel_y      <= pixel_y_nxt;
      first_pixel  <= first_pixel_nxt;
      line_end     <= line_end_nxt;
      frame_end    <= frame_end_nxt;
    end
  end

`ifdef VGA_TIMING_ADV7123_EN
  // The DAC blanking pin shares the video_on term so both stay cycle-aligned.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      adv7123_vga_blank_n <= 1'b0;
    end else begin
      adv7123_vga_blank_n <= video_on_nxt;
    end
  end

  assign adv7123_vga_sync_n = 1'b0;
  assign adv7123_vga_clk    = clk_vga;
`else
  // Plain VGA build: the DAC control pins are not present.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: an arithmetic position model queues the expected outputs per clock.
// A second instance with active-high syncs runs in lock-step to cover the polarity parameters.
module tb_vga_timing_gen;

  localparam int HVA = 8;
  localparam int HFP = 2;
  localparam int HSP = 3;
  localparam int HBP = 2;
  localparam int VVA = 4;
  localparam int VFP = 1;
  localparam int VSP = 2;
  localparam int VBP = 1;
  localparam int HT  = HVA + HFP + HSP + HBP;
  localparam int VT  = VVA + VFP + VSP + VBP;

  logic       clk_vga = 1'b0;
  logic       rst     = 1'b1;
  logic       en      = 1'b0;
  logic       vga_hsync, vga_vsync, vga_video_on;
  logic [2:0] pixel_x;
  logic [1:0] pixel_y;
  logic       first_pixel, line_end, frame_end;

  logic       pol_hsync, pol_vsync, pol_video_on;
  logic [2:0] pol_pixel_x;
  logic [1:0] pol_pixel_y;
  logic       pol_first_pixel, pol_line_end, pol_frame_end;

`ifdef VGA_TIMING_ADV7123_EN
  logic blank_n, sync_n, dac_clk;
  logic pol_blank_n, pol_sync_n, pol_dac_clk;
`endif

  always #5 clk_vga = ~clk_vga;

  vga_timing_gen #(
    .HVA(HVA), .HFP(HFP), .HSP(HSP), .HBP(HBP),
    .VVA(VVA), .VFP(VFP), .VSP(VSP), .VBP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk_vga      (clk_vga),
    .rst          (rst),
    .en           (en),
    .vga_hsync    (vga_hsync),
    .vga_vsync    (vga_vsync),
    .vga_video_on (vga_video_on),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .first_pixel  (first_pixel),
    .line_end     (line_end),
    .frame_end    (frame_end)
`ifdef VGA_TIMING_ADV7123_EN
    ,
    .adv7123_vga_blank_n (blank_n),
    .adv7123_vga_sync_n  (sync_n),
    .adv7123_vga_clk     (dac_clk)
`endif
  );

  vga_timing_gen #(
    .HVA(HVA), .HFP(HFP), .HSP(HSP), .HBP(HBP),
    .VVA(VVA), .VFP(VFP), .VSP(VSP), .VBP(VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_pol (
    .clk_vga      (clk_vga),
    .rst          (rst),
    .en           (en),
    .vga_hsync    (pol_hsync),
    .vga_vsync    (pol_vsync),
    .vga_video_on (pol_video_on),
    .pixel_x      (pol_pixel_x),
    .pixel_y      (pol_pixel_y),
    .first_pixel  (pol_first_pixel),
    .line_end     (pol_line_end),
    .frame_end    (pol_frame_end)
`ifdef VGA_TIMING_ADV7123_EN
    ,
    .adv7123_vga_blank_n (pol_blank_n),
    .adv7123_vga_sync_n  (pol_sync_n),
    .adv7123_vga_clk     (pol_dac_clk)
`endif
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vid;
    logic [2:0] px;
    logic [1:0] py;
    logic       fp;
    logic       le;
    logic       fe;
    logic       hs_p;
    logic       vs_p;
  } exp_t;

  exp_t sb[$];
  int   mh = 0;
  int   mv = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int   cyc, first_fp_at, fe_cnt, le_cnt, vid_cnt, max_px, max_py;
  int   vs_run, vs_max_run, vs_runs, pol_hs_high;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: position within the frame maps directly onto region boundaries.
  function automatic exp_t model_step(input logic r, input logic e);
    exp_t x;
    logic hva, vva;
    x = '0;
    x.hs = 1'b1;
    x.vs = 1'b1;
    if (r || !e) begin
      mh = 0;
      mv = 0;
    end else begin
      hva    = (mh >= HSP + HBP) && (mh < HSP + HBP + HVA);
      vva    = (mv >= VSP + VBP) && (mv < VSP + VBP + VVA);
      x.hs   = !(mh < HSP);
      x.vs   = !(mv < VSP);
      x.hs_p = (mh < HSP);
      x.vs_p = (mv < VSP);
      x.vid  = hva && vva;
      x.px   = hva ? 3'(mh - (HSP + HBP)) : 3'd0;
      x.py   = vva ? 2'(mv - (VSP + VBP)) : 2'd0;
      x.fp   = (mh == HSP + HBP) && (mv == VSP + VBP);
      x.le   = (mh == HT - 1);
      x.fe   = (mh == HT - 1) && (mv == VT - 1);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    return x;
  endfunction

  task automatic clear_stats();
    cyc = 0; first_fp_at = 0; fe_cnt = 0; le_cnt = 0; vid_cnt = 0;
    max_px = 0; max_py = 0; vs_run = 0; vs_max_run = 0; vs_runs = 0; pol_hs_high = 0;
  endtask

  task automatic sample();
    exp_t x;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    checkOutput("hsync",       32'(vga_hsync),       32'(x.hs));
    checkOutput("vsync",       32'(vga_vsync),       32'(x.vs));
    checkOutput("video_on",    32'(vga_video_on),    32'(x.vid));
    checkOutput("pixel_x",     32'(pixel_x),         32'(x.px));
    checkOutput("pixel_y",     32'(pixel_y),         32'(x.py));
    checkOutput("first_pixel", 32'(first_pixel),     32'(x.fp));
    checkOutput("line_end",    32'(line_end),        32'(x.le));
    checkOutput("frame_end",   32'(frame_end),       32'(x.fe));
    checkOutput("pol_hsync",   32'(pol_hsync),       32'(x.hs_p));
    checkOutput("pol_vsync",   32'(pol_vsync),       32'(x.vs_p));
`ifdef VGA_TIMING_ADV7123_EN
    checkOutput("blank_n",     32'(blank_n),         32'(x.vid));
    checkOutput("sync_n",      32'(sync_n),          32'd0);
    checkOutput("dac_clk",     32'(dac_clk),         32'd0);
`endif
    cyc++;
    if (first_pixel && first_fp_at == 0) first_fp_at = cyc;
    if (frame_end) fe_cnt++;
    if (line_end) le_cnt++;
    if (pol_hsync) pol_hs_high++;
    if (vga_video_on && cyc <= HT * VT) begin
      vid_cnt++;
      if (int'(pixel_x) > max_px) max_px = int'(pixel_x);
      if (int'(pixel_y) > max_py) max_py = int'(pixel_y);
    end
    if (!vga_vsync) begin
      vs_run++;
    end else if (vs_run > 0) begin
      vs_runs++;
      if (vs_run > vs_max_run) vs_max_run = vs_run;
      vs_run = 0;
    end
  endtask

  // Drive one input pattern for n clocks, queueing the expectation for each edge.
  task automatic applyStimulus(input logic r, input logic e, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r;
      en  = e;
      sb.push_back(model_step(r, e));
      @(posedge clk_vga);
      @(negedge clk_vga);
      sample();
    end
  endtask

  initial begin
    $display("[TB] reset and three full frames");
    clear_stats();
    applyStimulus(1'b1, 1'b1, 3);
    clear_stats();
    applyStimulus(1'b0, 1'b1, 3 * HT * VT);
    checkOutput("first_pixel_cycle", 32'(first_fp_at), 32'd51);
    checkOutput("frame_end_count",   32'(fe_cnt),      32'd3);
    checkOutput("line_end_count",    32'(le_cnt),      32'(3 * VT));
    checkOutput("video_on_cycles",   32'(vid_cnt),     32'd32);
    checkOutput("pixel_x_max",       32'(max_px),      32'd7);
    checkOutput("pixel_y_max",       32'(max_py),      32'd3);
    checkOutput("vsync_low_run",     32'(vs_max_run),  32'd30);
    checkOutput("vsync_low_runs",    32'(vs_runs),     32'd3);
    checkOutput("pol_hsync_high",    32'(pol_hs_high), 32'(3 * HSP * VT));

    $display("[TB] enable dropped mid-frame");
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 69);
    applyStimulus(1'b0, 1'b0, 5);
    clear_stats();
    applyStimulus(1'b0, 1'b1, HT * VT);
    checkOutput("reenable_first_pixel", 32'(first_fp_at), 32'd51);
    checkOutput("reenable_frame_end",   32'(fe_cnt),      32'd1);

    $display("[TB] random enable and reset activity");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) != 0),
                    int'($urandom_range(1, 20)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; next generation of the fixed-resolution sync block.
- All horizontal and vertical timings and sync polarities are module parameters, not global defines.
- Adds a run-enable, registered pixel coordinates, and line/frame strobes.
- Sits between the pixel clock domain (clk_vga) and the frame-buffer/pixel pipeline; drives the DAC sync pins.

Parameters:
HVA, 640, horizontal visible pixels
HFP, 16, horizontal front porch (pixels)
HSP, 96, horizontal sync pulse (pixels)
HBP, 48, horizontal back porch (pixels)
VVA, 480, vertical visible lines
VFP, 10, vertical front porch (lines)
VSP, 2, vertical sync pulse (lines)
VBP, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync (0 = active-low)

Ports:
clk_vga  input  1  pixel clock
rst  input  1  synchronous, active-high reset
en  input  1  run enable; low holds the generator at line 0 / pixel 0
vga_hsync  output  1  horizontal sync, polarity per HSYNC_POL
vga_vsync  output  1  vertical sync, polarity per VSYNC_POL
vga_video_on  output  1  inside the visible area
pixel_x  output  $clog2(HVA)  visible column, 0..HVA-1
pixel_y  output  $clog2(VVA)  visible row, 0..VVA-1
first_pixel  output  1  1-cycle strobe on pixel (0,0)
line_end  output  1  1-cycle strobe on the last clock of every line
frame_end  output  1  1-cycle strobe on the last clock of every frame

Behaviour:
- Totals: HT = HVA+HFP+HSP+HBP; VT = VVA+VFP+VSP+VBP.
- Counters:
  - h_cnt counts 0..HT-1 and wraps to 0.
  - v_cnt counts 0..VT-1; it advances only when h_cnt == HT-1 and wraps to 0 after VT-1.
  - Widths are $clog2(HT) and $clog2(VT).
- Region order within a line (the same order applies to v_cnt within a frame), starting from count 0:
  - SP: [0, HSP)
  - BP: [HSP, HSP+HBP)
  - VA: [HSP+HBP, HSP+HBP+HVA)
  - FP: the remaining counts
- Region tracking is a 4-state one-hot FSM per axis (SP->BP->VA->FP->SP). State and counter must always be consistent.
- Output latency: every output is registered and reflects the counter state of the previous cycle (1-cycle latency).
- Output definitions:
  - vga_hsync = HSYNC_POL when h is in SP, else ~HSYNC_POL. vga_vsync is defined the same way with v and VSYNC_POL.
  - vga_video_on = h in VA and v in VA.
  - pixel_x = h_cnt-(HSP+HBP) when h is in VA, else 0. pixel_y = v_cnt-(VSP+VBP) when v is in VA, else 0. No wrap inside VA.
  - first_pixel = (h_cnt == HSP+HBP) and (v_cnt == VSP+VBP).
  - line_end = (h_cnt == HT-1).
  - frame_end = (h_cnt == HT-1) and (v_cnt == VT-1).
- Reset values:
  - h_cnt = v_cnt = 0; both FSMs in SP.
  - vga_hsync = ~HSYNC_POL; vga_vsync = ~VSYNC_POL (inactive).
  - video_on, pixel_x, pixel_y, first_pixel, line_end, frame_end = 0.
- en = 0 (at any point, including mid-frame): on the next edge the counters/FSMs return to the reset state and all outputs take their reset values. They hold there while en = 0.
- en rising: h_cnt = 0 in the first enabled cycle. Outputs show SP (sync active) one cycle later.
- rst has priority over en.
- Elaboration check: every parameter must be >= 1 (fatal error otherwise). HT and VT exceeding the counter range is impossible by construction.

Optional Feature:
- Macro: VGA_TIMING_ADV7123_EN.
- When defined, add three outputs:
  - adv7123_vga_blank_n (1): registered copy of the same next-state term as vga_video_on, so it is cycle-aligned with vga_video_on. Reset value 0.
  - adv7123_vga_sync_n (1): tied 0.
  - adv7123_vga_clk (1): equal to clk_vga.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Common setup: all scenarios use HVA=8, HFP=2, HSP=3, HBP=2, VVA=4, VFP=1, VSP=2, VBP=1 (HT=15, VT=8, frame = 120 cycles) unless stated, with en=1.
- Reset/first frame: hold rst for 3 cycles with en=1, then release -> all outputs at reset values during rst; vga_hsync low on cycles 1..3 after release; first_pixel high only on cycle 51 with pixel_x=0, pixel_y=0.
- Periodicity: run 3 frames -> frame_end high every 120 cycles (cycle 120, 240, 360); line_end every 15 cycles; vga_vsync low for exactly 30 consecutive cycles per frame.
- Coordinates: over one frame -> vga_video_on high for exactly 32 cycles; pixel_x sweeps 0..7 and pixel_y sweeps 0..3 while it is high; pixel_x=pixel_y=0 whenever it is low.
- Enable mid-frame: drop en at cycle 70 for 5 cycles, then restore -> outputs at reset values by cycle 71; after re-enable, first_pixel occurs exactly 51 cycles after the first enabled cycle.
- Polarity: HSYNC_POL=1, VSYNC_POL=1 -> vga_hsync high for 3 cycles per line and low otherwise; reset value is 0.
- Macro on (VGA_TIMING_ADV7123_EN): adv7123_vga_blank_n equals vga_video_on on every cycle; adv7123_vga_sync_n stays 0 throughout.
